// File: rtl/apb2_master.sv
// APB2 initiator: turns a valid/ready command stream into SETUP/ACCESS transfers
// and returns each completion on a one-cycle response strobe.
module apb2_master #(
  parameter int unsigned ADDR_BITS = 4,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [DATA_BITS-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic                 rsp_write,
  output logic [DATA_BITS-1:0] rsp_rdata,
  output logic [ADDR_BITS-1:0] PADDR,
  output logic                 PSEL,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [DATA_BITS-1:0] PWDATA,
  input  logic [DATA_BITS-1:0] PRDATA
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 ready_q, ready_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic [ADDR_BITS-1:0] paddr_q, paddr_d;
  logic                 pwrite_q, pwrite_d;
  logic [DATA_BITS-1:0] pwdata_q, pwdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_write_q, rsp_write_d;
  logic [DATA_BITS-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 accept;

  assign accept = cmd_valid && ready_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      S_IDLE:   if (accept) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: begin
        // Edge ending ACCESS completes the transfer and samples PRDATA
        rsp_valid_d = 1'b1;
        rsp_write_d = pwrite_q;
        rsp_rdata_d = pwrite_q ? '0 : PRDATA;
        state_d     = accept ? S_SETUP : S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase

    if (accept) begin
      paddr_d  = cmd_addr;
      pwrite_d = cmd_write;
      pwdata_d = cmd_write ? cmd_wdata : '0;
    end

    // Pin values are derived from the next state so they leave the block registered
    ready_d   = (state_d != S_SETUP);
    psel_d    = (state_d != S_IDLE);
    penable_d = (state_d == S_ACCESS);
  end

  assign cmd_ready = ready_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb2_master.sv
// Bench for apb2_master: APB2 slave memory, transaction-level timeline model,
// a vector table for back-to-back corners, and randomized command traffic.
module tb_apb2_master;

  localparam int unsigned AW   = 4;
  localparam int unsigned DW   = 8;
  localparam int          MAXE = 1024;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] PADDR;
  logic          PSEL, PENABLE, PWRITE;
  logic [DW-1:0] PWDATA, PRDATA;

  apb2_master #(.ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  // APB2 slave memory model
  logic          slv_clear;
  logic [DW-1:0] slv_mem [16];
  int            wcnt, rcnt;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_wdata;

  assign PRDATA = slv_mem[PADDR];

  always @(posedge PCLK) begin
    if (slv_clear) begin
      for (int i = 0; i < 16; i++) slv_mem[i] <= '0;
      wcnt <= 0; rcnt <= 0; last_addr <= '0; last_wdata <= '0;
    end else if (PSEL && PENABLE) begin
      if (PWRITE) begin
        slv_mem[PADDR] <= PWDATA;
        wcnt       <= wcnt + 1;
        last_addr  <= PADDR;
        last_wdata <= PWDATA;
      end else begin
        rcnt <= rcnt + 1;
      end
    end
  end

  // Reference model: each accepted command at edge e occupies the bus for the two
  // following cycles and completes one cycle later; memory applied in accept order.
  int            checks = 0, errors = 0, edge_n;
  logic          exp_psel [MAXE];
  logic          exp_pen  [MAXE];
  logic          exp_rv   [MAXE];
  logic          exp_rw   [MAXE];
  logic [DW-1:0] exp_rd   [MAXE];
  logic [DW-1:0] mdl_mem  [16];
  logic          exp_ready, exp_pwrite;
  logic [AW-1:0] exp_paddr;
  logic [DW-1:0] exp_pwdata, rd_hold;
  logic          acc_o;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (edge %0d): got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  task automatic model_reset();
    edge_n = 0; exp_ready = 1'b0; exp_pwrite = 1'b0;
    exp_paddr = '0; exp_pwdata = '0; rd_hold = '0;
    for (int i = 0; i < MAXE; i++) begin
      exp_psel[i] = 1'b0; exp_pen[i] = 1'b0; exp_rv[i] = 1'b0;
      exp_rw[i] = 1'b0; exp_rd[i] = '0;
    end
  endtask

  task automatic step(input logic v, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    cmd_valid = v; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    @(posedge PCLK);
    edge_n++;
    acc_o = v && exp_ready;
    if (acc_o) begin
      exp_paddr  = a;
      exp_pwrite = w;
      exp_pwdata = w ? d : '0;
      exp_psel[edge_n] = 1'b1;
      exp_psel[edge_n+1] = 1'b1;
      exp_pen[edge_n+1] = 1'b1;
      exp_rv[edge_n+2] = 1'b1;
      exp_rw[edge_n+2] = w;
      exp_rd[edge_n+2] = w ? '0 : mdl_mem[a];
      if (w) mdl_mem[a] = d;
    end
    exp_ready = !acc_o;
    if (exp_rv[edge_n]) rd_hold = exp_rd[edge_n];
    @(negedge PCLK);
    chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
    chk("PSEL", 32'(PSEL), 32'(exp_psel[edge_n]));
    chk("PENABLE", 32'(PENABLE), 32'(exp_pen[edge_n]));
    chk("PADDR", 32'(PADDR), 32'(exp_paddr));
    chk("PWRITE", 32'(PWRITE), 32'(exp_pwrite));
    chk("PWDATA", 32'(PWDATA), 32'(exp_pwdata));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv[edge_n]));
    if (exp_rv[edge_n]) chk("rsp_write", 32'(rsp_write), 32'(exp_rw[edge_n]));
    chk("rsp_rdata", 32'(rsp_rdata), 32'(rd_hold));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
  endtask

  typedef struct {
    logic          v; logic w; logic [AW-1:0] a; logic [DW-1:0] d;
    logic          psel; logic pen; logic rv; logic [DW-1:0] rd;
  } vec_t;
  vec_t tbl [15];

  logic          pend, rw;
  logic [AW-1:0] ra;
  logic [DW-1:0] rdat, old5;
  int            wc0, rc0;

  initial begin
    // back-to-back writes 0..3 (each held until accepted), then write/read at 0xF
    tbl[0]  = '{1'b1, 1'b1, 4'h0, 8'h10, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 4'h1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 1'b1, 4'h1, 8'h11, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[3]  = '{1'b1, 1'b1, 4'h2, 8'h12, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[4]  = '{1'b1, 1'b1, 4'h2, 8'h12, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[5]  = '{1'b1, 1'b1, 4'h3, 8'h13, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[6]  = '{1'b1, 1'b1, 4'h3, 8'h13, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[7]  = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[9]  = '{1'b1, 1'b1, 4'hF, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[10] = '{1'b1, 1'b0, 4'hF, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[11] = '{1'b1, 1'b0, 4'hF, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[12] = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[13] = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF};
    tbl[14] = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF};

    PRESET = 1'b1; slv_clear = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    for (int i = 0; i < 16; i++) mdl_mem[i] = '0;
    model_reset();
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_paddr", 32'(PADDR), 32'd0);
    slv_clear = 1'b0;
    PRESET = 1'b0;

    idle(1);
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d);
      chk("tbl_psel", 32'(PSEL), 32'(tbl[i].psel));
      chk("tbl_penable", 32'(PENABLE), 32'(tbl[i].pen));
      chk("tbl_rsp_valid", 32'(rsp_valid), 32'(tbl[i].rv));
      chk("tbl_rsp_rdata", 32'(rsp_rdata), 32'(tbl[i].rd));
    end
    for (int i = 0; i < 4; i++) chk("b2b_mem", 32'(slv_mem[i]), 32'(8'h10 + 8'(i)));
    chk("b2b_wcnt", 32'(wcnt), 32'd5);

    // single write
    step(1'b1, 1'b1, 4'h3, 8'hA5);
    idle(3);
    chk("wr_wcnt", 32'(wcnt), 32'd6);
    chk("wr_last_addr", 32'(last_addr), 32'h3);
    chk("wr_last_data", 32'(last_wdata), 32'hA5);

    // preload then read back
    step(1'b1, 1'b1, 4'h7, 8'h5C);
    idle(2);
    rc0 = rcnt;
    step(1'b1, 1'b0, 4'h7, 8'hEE);
    idle(3);
    chk("rd_rcnt", 32'(rcnt), 32'(rc0 + 1));
    chk("rd_rdata", 32'(rsp_rdata), 32'h5C);

    // idle gap after one command
    step(1'b1, 1'b1, 4'h9, 8'h3C);
    idle(5);
    chk("gap_psel", 32'(PSEL), 32'd0);
    chk("gap_paddr", 32'(PADDR), 32'h9);
    chk("gap_pwdata", 32'(PWDATA), 32'h3C);

    // randomized traffic; a command is held until accepted
    pend = 1'b0; rw = 1'b0; ra = '0; rdat = '0;
    for (int i = 0; i < 300; i++) begin
      if (!pend && ($urandom_range(0, 2) != 0)) begin
        pend = 1'b1; rw = 1'($urandom); ra = AW'($urandom); rdat = DW'($urandom);
      end
      step(pend, rw, ra, rdat);
      if (acc_o) pend = 1'b0;
    end
    for (int k = 0; k < 4 && pend; k++) begin
      step(1'b1, rw, ra, rdat);
      if (acc_o) pend = 1'b0;
    end
    chk("rand_drained", 32'(pend), 32'd0);
    idle(4);
    for (int i = 0; i < 16; i++) chk("rand_mem", 32'(slv_mem[i]), 32'(mdl_mem[i]));

    // reset in the middle of ACCESS aborts the write
    old5 = mdl_mem[5];
    step(1'b1, 1'b1, 4'h5, 8'h77);
    chk("abort_accepted", 32'(acc_o), 32'd1);
    step(1'b0, 1'b0, '0, '0);
    wc0 = wcnt;
    #2 PRESET = 1'b1;
    #1;
    chk("abort_psel", 32'(PSEL), 32'd0);
    chk("abort_penable", 32'(PENABLE), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd0);
    @(posedge PCLK);
    @(negedge PCLK);
    chk("abort_wcnt", 32'(wcnt), 32'(wc0));
    chk("abort_rsp_valid2", 32'(rsp_valid), 32'd0);
    PRESET = 1'b0;
    mdl_mem[5] = old5;
    model_reset();
    idle(1);
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    step(1'b1, 1'b0, 4'h5, 8'h00);
    idle(3);
    chk("post_rst_rdata", 32'(rsp_rdata), 32'(old5));
    chk("post_rst_mem5", 32'(slv_mem[5]), 32'(old5));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb2_master.md
Name: apb2_master

Overview:
- Synthesizable APB2 (AMBA 2, no PREADY/PSLVERR) initiator.
- Converts a single-entry valid/ready command stream into APB2 SETUP/ACCESS transfers on a slave bus, and returns read data on a one-cycle response strobe.
- Sits between register-access logic (host bridge, test sequencer) and APB2 peripherals.
- Verified against the codebase's APB2 slave memory model.

Parameters:
- ADDR_BITS, 4, width of PADDR and cmd_addr.
- DATA_BITS, 8, width of PWDATA, PRDATA, cmd_wdata and rsp_rdata.

Ports:
- PCLK  input  1  bus and logic clock; all state on rising edge.
- PRESET  input  1  reset, asynchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_BITS  target address.
- cmd_wdata  input  DATA_BITS  write data; ignored for reads.
- rsp_valid  output  1  one-cycle pulse: transfer completed.
- rsp_write  output  1  direction of the completed transfer.
- rsp_rdata  output  DATA_BITS  read data; 0 for writes.
- PADDR  output  ADDR_BITS  APB address.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PWDATA  output  DATA_BITS  APB write data.
- PRDATA  input  DATA_BITS  APB read data.

Behaviour:
- One clock (PCLK); reset PRESET is asynchronous, active-high.
- While PRESET is high, all outputs are 0 and state = IDLE. This includes cmd_ready, which stays 0 during reset and goes to 1 on the first cycle after release.
- Reset mid-transfer aborts immediately: PSEL and PENABLE drop asynchronously, and no rsp_valid is produced.
- All APB outputs and response outputs are registered; no combinational path from cmd_* to the APB pins.
- States:
  - IDLE: PSEL=0, PENABLE=0. cmd_ready=1.
  - SETUP: PSEL=1, PENABLE=0. cmd_ready=0.
  - ACCESS: PSEL=1, PENABLE=1. cmd_ready=1.
- Command acceptance: a command is accepted on a rising edge where cmd_valid && cmd_ready.
  - At acceptance, PADDR, PWRITE and PWDATA are loaded from cmd_addr, cmd_write and cmd_wdata.
  - For reads, PWDATA loads 0.
- Transitions:
  - IDLE -> SETUP on acceptance, else stay.
  - SETUP -> ACCESS unconditionally, after exactly one cycle.
  - ACCESS -> SETUP if a command is accepted on that edge (back-to-back; PSEL stays 1, PENABLE drops to 0); otherwise ACCESS -> IDLE.
- ACCESS lasts exactly one cycle. There is no wait-state support (APB2).
- PADDR, PWRITE and PWDATA are stable from SETUP through ACCESS, and hold their last values in IDLE.
- Latency: acceptance at edge N gives SETUP in cycle N+1 and ACCESS in cycle N+2.
- Response: PRDATA is sampled on the edge ending ACCESS.
  - rsp_valid=1 for exactly one cycle (N+3), with rsp_write = the transfer's direction.
  - rsp_rdata = sampled PRDATA for reads, 0 for writes.
  - rsp_rdata holds its value until the next response.
- Maximum throughput: one transfer per 2 cycles with cmd_valid held high.
- Commands presented while cmd_ready=0 are not consumed; the upstream must hold them stable.
- cmd_valid deasserting in SETUP has no effect on the in-flight transfer.
- Address wrap: none internal; PADDR is the command address verbatim. Max address 2^ADDR_BITS-1 is legal.

Test Plan:
1. Reset: assert PRESET mid-ACCESS -> PSEL, PENABLE and rsp_valid go 0 immediately; slave write_count is unchanged; cmd_ready=1 on the first cycle after release.
2. Single write of addr 0x3, data 0xA5 -> one SETUP cycle then one ACCESS cycle. Slave write_count=1, last_addr=0x3, last_write=0xA5. rsp_valid pulses once at N+3 with rsp_write=1, rsp_rdata=0.
3. Read back: preload slave mem[0x7]=0x5C, issue read of 0x7 -> PWRITE=0 throughout; rsp_rdata=0x5C at N+3; slave read_count=1; PWDATA=0.
4. Back-to-back: hold cmd_valid for 4 writes to addrs 0x0..0x3 with data 0x10..0x13 -> PSEL stays high across all 8 cycles, PENABLE toggles 0,1,0,1...; 4 rsp_valid pulses 2 cycles apart; slave mem matches.
5. Mixed write-then-read at the same address 0xF (max address), data 0xFF -> the read returns 0xFF; the read's SETUP directly follows the write's ACCESS.
6. Idle gap: command accepted, then cmd_valid low for 5 cycles -> returns to IDLE with PSEL=0; PADDR and PWDATA hold their last values; no spurious rsp_valid.
